// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encoding, arbitration modes and flattened-slice helper
// for the N-channel bus arbiter.
package bus_pkg;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotating priority encoder; picks the first request at or after
// i_base (round-robin) or the lowest index (fixed).
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_base,
  input  logic          i_rr,
  output logic [IW-1:0] o_grant,
  output logic          o_valid
);
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_base} + (IW + 1)'(k);
      w_idx = !i_rr ? IW'(k) : (w_sum >= (IW + 1)'(N) ? IW'(w_sum - (IW + 1)'(N)) : IW'(w_sum));
      if (i_req[w_idx]) begin
        o_grant = w_idx;
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-channel request-pulse arbiter onto one downstream bus,
// with per-channel pending slots, sticky overflow and a WAIT watchdog.
module bus_arbiter_n
  import bus_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 0
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [NUM_CH-1:0]            up_request_enable,
  input  logic [NUM_CH-1:0]            up_mode,
  input  logic [NUM_CH*ADDR_W-1:0]     up_addr,
  input  logic [NUM_CH*DATA_W-1:0]     up_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0]   up_wstrb,
  output logic [NUM_CH-1:0]            up_response_enable,
  output logic [DATA_W-1:0]            up_resp_data,
  output logic                         down_request_enable,
  output logic                         down_mode,
  output logic [ADDR_W-1:0]            down_addr,
  output logic [DATA_W-1:0]            down_wdata,
  output logic [DATA_W/8-1:0]          down_wstrb,
  input  logic                         down_response_enable,
  input  logic [DATA_W-1:0]            down_resp_data,
  output logic                         busy,
  output logic [$clog2(NUM_CH)-1:0]    grant_id,
  output logic [NUM_CH-1:0]            overflow,
  output logic                         timeout_err
);
  localparam int SW = DATA_W / 8;
  localparam int IW = $clog2(NUM_CH);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_pend, r_ovf, r_mode, r_uresp;
  logic [ADDR_W-1:0]   r_addr [NUM_CH];
  logic [DATA_W-1:0]   r_wdata [NUM_CH];
  logic [SW-1:0]       r_wstrb [NUM_CH];
  logic [IW-1:0]       r_gid, r_ptr;
  logic [CW-1:0]       r_cnt;
  logic                r_dreq, r_dmode, r_terr;
  logic [ADDR_W-1:0]   r_daddr;
  logic [DATA_W-1:0]   r_dwdata, r_rdata;
  logic [SW-1:0]       r_dwstrb;
  logic [IW-1:0]       w_g;
  logic                w_valid, w_to, w_fin;
  logic [NUM_CH-1:0]   w_clr;

  rr_picker #(.N(NUM_CH), .IW(IW)) u_pick (
    .i_req(r_pend), .i_base(r_ptr), .i_rr(ARB_MODE == ARB_RR),
    .o_grant(w_g), .o_valid(w_valid)
  );

  // A real response wins over a watchdog expiry landing in the same cycle.
  assign w_to  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  assign w_fin = (r_state == ST_WAIT) && (down_response_enable || w_to);
  assign w_clr = w_fin ? NUM_CH'(1) << r_gid : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend <= '0;
      r_ovf  <= '0;
      r_mode <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_wstrb[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (up_request_enable[i] && (!r_pend[i] || w_clr[i])) begin
          r_pend[i]  <= 1'b1;
          r_mode[i]  <= up_mode[i];
          r_addr[i]  <= up_addr[slice_lo(i, ADDR_W) +: ADDR_W];
          r_wdata[i] <= up_wdata[slice_lo(i, DATA_W) +: DATA_W];
          r_wstrb[i] <= up_wstrb[slice_lo(i, SW) +: SW];
        end else if (w_clr[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (up_request_enable[i] && r_pend[i] && !w_clr[i]) r_ovf[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_gid    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_dreq   <= 1'b0;
      r_dmode  <= 1'b0;
      r_daddr  <= '0;
      r_dwdata <= '0;
      r_dwstrb <= '0;
      r_uresp  <= '0;
      r_rdata  <= '0;
      r_terr   <= 1'b0;
    end else begin
      r_dreq  <= 1'b0;
      r_uresp <= '0;
      r_rdata <= '0;
      r_terr  <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_valid) begin
          r_state  <= ST_WAIT;
          r_gid    <= w_g;
          r_cnt    <= '0;
          r_dreq   <= 1'b1;
          r_dmode  <= r_mode[w_g];
          r_daddr  <= r_addr[w_g];
          r_dwdata <= r_wdata[w_g];
          r_dwstrb <= r_wstrb[w_g];
        end
      end else if (w_fin) begin
        r_state <= ST_IDLE;
        r_uresp <= w_clr;
        r_rdata <= down_response_enable ? down_resp_data : '0;
        r_terr  <= !down_response_enable;
        if (ARB_MODE == ARB_RR) r_ptr <= (r_gid == IW'(NUM_CH - 1)) ? '0 : r_gid + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign up_response_enable  = r_uresp;
  assign up_resp_data        = r_rdata;
  assign down_request_enable = r_dreq;
  assign down_mode           = r_dmode;
  assign down_addr           = r_daddr;
  assign down_wdata          = r_dwdata;
  assign down_wstrb          = r_dwstrb;
  assign busy                = (r_state == ST_WAIT);
  assign grant_id            = r_gid;
  assign overflow            = r_ovf;
  assign timeout_err         = r_terr;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: directed scoreboard bench; a 4-channel fixed-priority
// instance with watchdog and a 3-channel round-robin instance.
module tb_bus_arbiter_n;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   f_req = '0, f_mode = '0, f_uresp, f_ovf;
  logic [127:0] f_addr = '0, f_wdata = '0;
  logic [15:0]  f_wstrb = '0;
  logic [31:0]  f_rdata, f_daddr, f_dwdata, f_drdata = '0;
  logic [3:0]   f_dwstrb;
  logic         f_dreq, f_dmode, f_dresp = 1'b0, f_busy, f_terr;
  logic [1:0]   f_gid;

  logic [2:0]   rr_req = '0, rr_uresp, rr_ovf;
  logic [95:0]  rr_addr = {32'hC2, 32'hC1, 32'hC0};
  logic [31:0]  rr_rdata, rr_daddr, rr_dwdata, rr_drdata = '0;
  logic [3:0]   rr_dwstrb;
  logic         rr_dreq, rr_dmode, rr_dresp = 1'b0, rr_busy, rr_terr;
  logic [1:0]   rr_gid;

  bus_arbiter_n #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT(8)) u_f (
    .clk(clk), .rstn(rstn), .up_request_enable(f_req), .up_mode(f_mode), .up_addr(f_addr),
    .up_wdata(f_wdata), .up_wstrb(f_wstrb), .up_response_enable(f_uresp), .up_resp_data(f_rdata),
    .down_request_enable(f_dreq), .down_mode(f_dmode), .down_addr(f_daddr), .down_wdata(f_dwdata),
    .down_wstrb(f_dwstrb), .down_response_enable(f_dresp), .down_resp_data(f_drdata),
    .busy(f_busy), .grant_id(f_gid), .overflow(f_ovf), .timeout_err(f_terr)
  );

  bus_arbiter_n #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT(0)) u_rr (
    .clk(clk), .rstn(rstn), .up_request_enable(rr_req), .up_mode(3'b000), .up_addr(rr_addr),
    .up_wdata(96'd0), .up_wstrb(12'd0), .up_response_enable(rr_uresp), .up_resp_data(rr_rdata),
    .down_request_enable(rr_dreq), .down_mode(rr_dmode), .down_addr(rr_daddr), .down_wdata(rr_dwdata),
    .down_wstrb(rr_dwstrb), .down_response_enable(rr_dresp), .down_resp_data(rr_drdata),
    .busy(rr_busy), .grant_id(rr_gid), .overflow(rr_ovf), .timeout_err(rr_terr)
  );

  typedef struct {logic [1:0] ch; logic m; logic [31:0] a; logic [31:0] wd; logic [3:0] st;} dexp_t;
  typedef struct {logic [3:0] oh; logic [31:0] d; logic te;} uexp_t;
  dexp_t dq[$];
  uexp_t uq[$];
  int    rq[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic f_set(input int ch, input logic m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input bit push);
    f_req[ch] = 1'b1;
    f_mode[ch] = m;
    f_addr[ch*32 +: 32] = a;
    f_wdata[ch*32 +: 32] = wd;
    f_wstrb[ch*4 +: 4] = st;
    if (push) dq.push_back('{ch[1:0], m, a, wd, st});
  endtask

  task automatic f_fire();
    step(1);
    f_req = '0;
  endtask

  task automatic f_down(input int lat);
    int n = 0;
    dexp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (!f_dreq && n < 20);
    chk("down_seen", f_dreq, 1);
    chk("down_lat", n, lat);
    if (dq.size() == 0) begin
      errors++;
      $error("FAIL down_scoreboard observed=unexpected_issue expected=none");
    end else begin
      e = dq.pop_front();
      chk("down_gid", f_gid, e.ch);
      chk("down_mode", f_dmode, e.m);
      chk("down_addr", f_daddr, e.a);
      chk("down_wdata", f_dwdata, e.wd);
      chk("down_wstrb", f_dwstrb, e.st);
    end
  endtask

  task automatic f_upchk(input int lat);
    int n = 0;
    uexp_t e;
    do begin
      @(negedge clk);
      n++;
    end while (f_uresp == 0 && n < 20);
    chk("up_lat", n, lat);
    e = uq.pop_front();
    chk("up_onehot", f_uresp, e.oh);
    chk("up_data", f_rdata, e.d);
    chk("up_terr", f_terr, e.te);
  endtask

  task automatic f_resp(input int ch, input logic [31:0] d);
    f_dresp = 1'b1;
    f_drdata = d;
    uq.push_back('{4'b0001 << ch, d, 1'b0});
    step(1);
    f_dresp = 1'b0;
    f_req = '0;
    f_upchk(1);
  endtask

  task automatic f_quiet(input string tag, input int n);
    int c = 0;
    repeat (n) begin
      @(negedge clk);
      if (f_uresp != 0 || f_dreq) c++;
    end
    chk(tag, c, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1);
  end

  initial begin
    step(2);
    chk("rst_busy", f_busy, 0);
    chk("rst_gid", f_gid, 0);
    chk("rst_ovf", f_ovf, 0);
    chk("rst_dreq", f_dreq, 0);
    chk("rst_uresp", f_uresp, 0);
    chk("rst_terr", f_terr, 0);
    chk("rst_daddr", f_daddr, 0);
    chk("rst_rr_gid", rr_gid, 0);
    rstn = 1'b1;
    step(1);
    // Single read on ch1: up at cycle 0, down at 2, response at 5, up resp at 6.
    f_set(1, 1'b0, 32'h8000_0010, 32'h0, 4'h0, 1);
    f_fire();
    f_down(2);
    chk("busy_wait", f_busy, 1);
    step(3);
    f_resp(1, 32'hDEAD_BEEF);
    chk("busy_idle", f_busy, 0);
    f_dresp = 1'b1;
    step(1);
    f_dresp = 1'b0;
    f_quiet("idle_resp_ignored", 4);
    // Fixed priority: ch3 and ch1 together; ch1 first, ch3 at k+2.
    f_set(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 1);
    f_set(3, 1'b1, 32'h0000_3000, 32'hA5A5_0303, 4'hC, 1);
    f_fire();
    f_down(2);
    step(1);
    f_resp(1, 32'h1111_0001);
    f_down(1);
    step(2);
    f_resp(3, 32'h3333_0003);
    chk("fixed_no_ovf", f_ovf, 0);
    // Overflow: second ch0 pulse while pending is dropped.
    f_set(0, 1'b0, 32'h0000_0A00, 32'h0, 4'h0, 1);
    f_fire();
    f_set(0, 1'b1, 32'h0000_0B00, 32'hBBBB_BBBB, 4'hF, 0);
    f_fire();
    f_down(1);
    chk("ovf_set", f_ovf, 4'b0001);
    step(1);
    f_resp(0, 32'h0000_00A0);
    f_quiet("ovf_no_reissue", 6);
    chk("ovf_sticky", f_ovf, 4'b0001);
    // New pulse on ch2 in the same cycle its transaction completes.
    f_set(2, 1'b0, 32'h0000_2000, 32'h0, 4'h0, 1);
    f_fire();
    f_down(2);
    step(1);
    f_set(2, 1'b1, 32'h0000_2004, 32'h2222_2222, 4'hF, 1);
    f_resp(2, 32'h2000_0001);
    f_down(1);
    chk("same_cycle_no_ovf", f_ovf, 4'b0001);
    step(1);
    f_resp(2, 32'h2000_0002);
    // Watchdog: no response for 8 WAIT cycles, then a late response is ignored.
    f_set(2, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 1);
    f_fire();
    f_down(2);
    uq.push_back('{4'b0100, 32'h0, 1'b1});
    f_upchk(8);
    step(3);
    f_dresp = 1'b1;
    f_drdata = 32'hFEED_F00D;
    step(1);
    f_dresp = 1'b0;
    f_quiet("late_resp_ignored", 5);
    // Async reset mid-WAIT, during the down pulse cycle.
    f_set(1, 1'b0, 32'h0000_5000, 32'h0, 4'h0, 1);
    f_fire();
    f_down(2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_dreq", f_dreq, 0);
    chk("arst_busy", f_busy, 0);
    chk("arst_gid", f_gid, 0);
    chk("arst_ovf", f_ovf, 0);
    chk("arst_daddr", f_daddr, 0);
    step(3);
    rstn = 1'b1;
    f_quiet("post_reset_quiet", 4);
    f_set(3, 1'b1, 32'h0000_6000, 32'h6666_0006, 4'h3, 1);
    f_fire();
    f_down(2);
    step(2);
    f_resp(3, 32'h6000_0006);
    // Round-robin with every channel re-requesting on completion.
    rr_req = 3'b111;
    step(1);
    rr_req = '0;
    foreach (rq[i]) rq.delete(i);
    for (int r = 0; r < 6; r++) rq.push_back(r % 3);
    for (int i = 0; i < 6; i++) begin
      int n = 0;
      int e;
      do begin
        @(negedge clk);
        n++;
      end while (!rr_dreq && n < 20);
      chk("rr_seen", rr_dreq, 1);
      e = rq.pop_front();
      chk("rr_gid", rr_gid, e);
      chk("rr_addr", rr_daddr, 32'hC0 + e);
      step(1);
      rr_dresp = 1'b1;
      rr_drdata = 32'h100 + i;
      rr_req = 3'b001 << e;
      step(1);
      rr_dresp = 1'b0;
      rr_req = '0;
      @(negedge clk);
      chk("rr_up", rr_uresp, 3'b001 << e);
      chk("rr_data", rr_rdata, 32'h100 + i);
    end
    chk("rr_no_ovf", rr_ovf, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
